// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: access-size and FSM state
// encodings, default RAM capacity and the lane mask helper.
package mau_pkg;

  localparam int MAU_MEM_BYTES_DEF = 1024;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } mau_size_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } mau_state_e;

  function automatic logic [63:0] size_mask(input mau_size_e sz);
    case (sz)
      SZ_BYTE: return 64'h0000_0000_0000_00FF;
      SZ_HALF: return 64'h0000_0000_0000_FFFF;
      SZ_WORD: return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane_merge.sv
// Combinational lane logic: extracts and extends load data from the read
// doubleword, and merges store bytes into it keeping the untouched bytes.
module mau_lane_merge
  import mau_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [63:0] wdata_i,
  input  mau_size_e   size_i,
  input  logic        sign_ext_i,
  output logic [63:0] load_data_o,
  output logic [63:0] store_data_o
);

  logic [63:0] mask;
  logic        msb;

  always_comb begin
    mask = size_mask(size_i);
    msb  = 1'b0;
    case (size_i)
      SZ_BYTE: msb = rdata_i[7];
      SZ_HALF: msb = rdata_i[15];
      SZ_WORD: msb = rdata_i[31];
      default: msb = 1'b0;
    endcase
    load_data_o = rdata_i & mask;
    // A double already fills all 64 bits, so msb stays 0 and nothing extends.
    if (sign_ext_i && msb) begin
      load_data_o = load_data_o | ~mask;
    end
    store_data_o = (rdata_i & ~mask) | (wdata_i & mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a one-cycle-latency doubleword RAM, doing
// read-modify-write for sub-double stores. Optional range check: MAU_BOUNDS_CHECK_EN.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int MEM_BYTES = MAU_MEM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        ram_we,
  output logic [63:0] ram_addr,
  output logic [63:0] ram_data_in,
  input  logic [63:0] ram_data_out
);

  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

  mau_state_e  state_q;
  logic        we_q;
  mau_size_e   size_q;
  logic        signed_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic        ram_we_q;
  logic [63:0] ram_data_q;
  logic        resp_valid_q;
  logic [63:0] resp_rdata_q;
  logic        resp_err_q;
  logic        reject_d;
  logic [63:0] load_data;
  logic [63:0] store_data;

  mau_lane_merge u_lane (
    .rdata_i      (ram_data_out),
    .wdata_i      (wdata_q),
    .size_i       (size_q),
    .sign_ext_i   (signed_q),
    .load_data_o  (load_data),
    .store_data_o (store_data)
  );

`ifdef MAU_BOUNDS_CHECK_EN
  assign reject_d = (req_addr > ADDR_MAX);
`else
  logic unused_addr_max;
  assign unused_addr_max = |ADDR_MAX;
  assign reject_d        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ram_we_q     <= 1'b0;
      ram_data_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q         <= req_we;
            size_q       <= mau_size_e'(req_size);
            signed_q     <= req_signed;
            addr_q       <= req_addr;
            wdata_q      <= req_wdata;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            if (reject_d) begin
              resp_err_q   <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= ST_RESP;
            end else if (req_we && (mau_size_e'(req_size) == SZ_DOUBLE)) begin
              // A full doubleword needs no read, so skip straight to the write.
              ram_data_q <= req_wdata;
              ram_we_q   <= 1'b1;
              state_q    <= ST_WR;
            end else begin
              state_q <= ST_RD;
            end
          end
        end
        ST_RD: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (we_q) begin
            ram_data_q <= store_data;
            ram_we_q   <= 1'b1;
            state_q    <= ST_WR;
          end else begin
            resp_rdata_q <= load_data;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end
        end
        ST_WR: begin
          ram_we_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          ram_we_q     <= 1'b0;
          resp_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = addr_q;
  assign ram_data_in = ram_data_q;

`ifdef MAU_BOUNDS_CHECK_EN
  assign resp_err = resp_err_q;
`else
  logic unused_err;
  assign unused_err = resp_err_q;
  assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-array RAM model, byte-level
// reference memory, directed cases and randomized load/store traffic.
module tb_mem_access_unit;

  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        ram_we;
  logic [63:0] ram_addr, ram_data_in, ram_data_out;

  int checks   = 0;
  int failures = 0;
  int we_cycles = 0;
  logic [63:0] exp_rdata = '0;
  logic        exp_err   = 1'b0;

  logic [7:0] ram     [MEM_BYTES+8];
  logic [7:0] ref_mem [MEM_BYTES+8];

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  function automatic logic [7:0] ram_byte(input logic [63:0] a, input int i);
    if (a < 64'(MEM_BYTES)) return ram[int'(a[15:0]) + i];
    return 8'h00;
  endfunction

  // RAM with a registered read port: data appears one cycle after the address.
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (ram_we) begin
        if (ram_addr < 64'(MEM_BYTES)) ram[int'(ram_addr[15:0]) + i] <= ram_data_in[8*i +: 8];
      end else begin
        ram_data_out[8*i +: 8] <= ram_byte(ram_addr, i);
      end
    end
  end

  always @(negedge clk) begin
    if (ram_we) we_cycles++;
    if (resp_valid && !rst) begin
      checks++;
      if (resp_rdata !== exp_rdata || resp_err !== exp_err) begin
        failures++;
        $display("FAIL resp_hold actual=%h/%b expected=%h/%b", resp_rdata, resp_err, exp_rdata, exp_err);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_load(input logic [63:0] a, input logic [1:0] sz, input logic sg);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    v = '0;
    for (int i = 0; i < n; i++) v = v + (64'(ref_mem[int'(a[15:0]) + i]) << (8*i));
    if (sg && n < 8 && v[8*n-1]) v = v - (64'd1 << (8*n)) ;
    return v;
  endfunction

  function automatic logic is_bad(input logic [63:0] a);
`ifdef MAU_BOUNDS_CHECK_EN
    return a > 64'(MEM_BYTES - 8);
`else
    return (a != a);
`endif
  endfunction

  task automatic txn(input logic we, input logic [1:0] sz, input logic sg,
                     input logic [63:0] a, input logic [63:0] wd, input int hold,
                     output logic [63:0] got);
    int lat, exp_lat, w;
    logic err;
    err = is_bad(a);
    w = 0;
    while (!req_ready && w < 50) begin @(posedge clk); #1; w++; end
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    exp_err   = err;
    exp_rdata = (we || err) ? 64'd0 : model_load(a, sz, sg);
    exp_lat   = err ? 1 : (!we ? 3 : (sz == 2'd3 ? 2 : 4));
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    we_cycles = 0;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency", 64'(lat), 64'(exp_lat));
    got = resp_rdata;
    repeat (hold) begin
      @(posedge clk); #1;
      chk("stall_valid_ready", {62'd0, resp_valid, req_ready}, 64'd2);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("release_idle", {62'd0, resp_valid, req_ready}, 64'd1);
    chk("ram_we_cycles", 64'(we_cycles), (we && !err) ? 64'd1 : 64'd0);
    if (we && !err)
      for (int i = 0; i < (1 << sz); i++) ref_mem[int'(a[15:0]) + i] = wd[8*i +: 8];
  endtask

  initial begin
    logic [63:0] got, a;
    logic [1:0]  sz;
    int mism;
    rst = 1'b1; req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
    req_addr = '0; req_wdata = '0; resp_ready = 0;
    for (int i = 0; i < MEM_BYTES + 8; i++) ref_mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {60'd0, req_ready, resp_valid, resp_err, ram_we}, 64'h8);
    chk("reset_rdata", resp_rdata, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fill the whole RAM with known data through double stores.
    for (int i = 0; i < MEM_BYTES; i += 8)
      txn(1'b1, 2'd3, 1'b0, 64'(i), {$urandom, $urandom}, 0, got);

    txn(1'b1, 2'd0, 1'b0, 64'h10, 64'h80, 0, got);
    txn(1'b0, 2'd0, 1'b1, 64'h10, 64'd0, 0, got);
    chk("ld_byte_signed", got, 64'hFFFF_FFFF_FFFF_FF80);

    txn(1'b1, 2'd3, 1'b0, 64'h20, 64'h1122_3344_5566_7788, 0, got);
    txn(1'b1, 2'd1, 1'b1, 64'h20, 64'hBEEF, 0, got);
    txn(1'b0, 2'd3, 1'b1, 64'h20, 64'd0, 0, got);
    chk("st_half_merge", got, 64'h1122_3344_5566_BEEF);

    txn(1'b1, 2'd3, 1'b0, 64'h7, 64'h0123_4567_89AB_CDEF, 0, got);
    txn(1'b0, 2'd2, 1'b0, 64'h7, 64'd0, 0, got);
    chk("ld_word_unaligned", got, 64'h0000_0000_89AB_CDEF);
    txn(1'b0, 2'd2, 1'b1, 64'h7, 64'd0, 5, got);
    chk("ld_word_signed", got, 64'hFFFF_FFFF_89AB_CDEF);

    // Reset during the WR cycle of a byte store must cancel the write.
    req_we = 1; req_size = 0; req_signed = 0; req_addr = 64'h41;
    req_wdata = {56'd0, ~ref_mem[16'h41]}; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wr_cycle_we", 64'(ram_we), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_we_drop", {62'd0, ram_we, resp_valid}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_byte_kept", 64'(ram[16'h41]), 64'(ref_mem[16'h41]));

`ifdef MAU_BOUNDS_CHECK_EN
    txn(1'b0, 2'd0, 1'b0, 64'd1017, 64'd0, 0, got);
    chk("oob_rdata", got, 64'd0);
    txn(1'b0, 2'd3, 1'b0, 64'd1016, 64'd0, 0, got);
`endif

    for (int n = 0; n < 250; n++) begin
      a  = 64'($urandom_range(0, MEM_BYTES - 8));
      sz = 2'($urandom);
`ifdef MAU_BOUNDS_CHECK_EN
      if ($urandom_range(0, 7) == 0) a = 64'($urandom_range(MEM_BYTES - 7, MEM_BYTES + 60));
`endif
      txn(1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom}, $urandom_range(0, 2), got);
    end

    mism = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (ram[i] !== ref_mem[i]) mism++;
    chk("ram_image", 64'(mism), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
